// File: rtl/scan_chk_pkg.sv
// scan_chk_pkg: shared types and constants for the scan-out CRC checker and the on-die signature generator.
package scan_chk_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    localparam int CRC_W = 32;
    localparam logic [CRC_W-1:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [CRC_W-1:0] CRC32_INIT = 32'hFFFFFFFF;
endpackage

// File: rtl/crc32_serial_step.sv
// crc32_serial_step: one bit of a normal-form, MSB-first CRC-32 update.
module crc32_serial_step
    import scan_chk_pkg::*;
(
    input  logic [CRC_W-1:0] crc,
    input  logic             bit_in,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crc_next
);
    always_comb crc_next = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bit_in) ? poly : '0);
endmodule

// File: rtl/scan_out_crc_checker.sv
// scan_out_crc_checker: frames the serial encrypted TDO stream into blocks and
// checks a CRC-32 over NUM_BLOCKS blocks against a golden signature.
module scan_out_crc_checker
    import scan_chk_pkg::*;
#(
    parameter int              BLOCK_W    = 128,
    parameter int              NUM_BLOCKS = 4,
    parameter logic [CRC_W-1:0] CRC_POLY  = CRC32_POLY,
    parameter logic [CRC_W-1:0] CRC_INIT  = CRC32_INIT
) (
    input  logic                              tck,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              serial_in,
    input  logic                              bit_valid,
    input  logic [CRC_W-1:0]                  golden_sig,
    output logic [BLOCK_W-1:0]                last_block,
    output logic [$clog2(NUM_BLOCKS+1)-1:0]   block_cnt,
    output logic [CRC_W-1:0]                  signature,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              overrun
);
    localparam int BIT_W = $clog2(BLOCK_W);
    localparam int BLK_W = $clog2(NUM_BLOCKS+1);

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d, crc_step;
    logic [BLOCK_W-2:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BLK_W-1:0]   block_cnt_q, block_cnt_d;
    logic [BLOCK_W-1:0] last_block_q, last_block_d;
    logic [CRC_W-1:0]   signature_q, signature_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d, overrun_q, overrun_d;
    logic               bit_last, blk_last;

    crc32_serial_step u_step (
        .crc      (crc_q),
        .bit_in   (serial_in),
        .poly     (CRC_POLY),
        .crc_next (crc_step)
    );

    assign bit_last = bit_cnt_q == BIT_W'(BLOCK_W-1);
    assign blk_last = block_cnt_q == BLK_W'(NUM_BLOCKS-1);

    // start takes priority in every state, including on the final bit of a frame
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        block_cnt_d  = block_cnt_q;
        last_block_d = last_block_q;
        signature_d  = signature_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        overrun_d    = overrun_q;
        if (start) begin
            state_d     = COLLECT;
            crc_d       = CRC_INIT;
            bit_cnt_d   = '0;
            block_cnt_d = '0;
            pass_d      = 1'b0;
            overrun_d   = 1'b0;
            busy_d      = 1'b1;
        end else if (state_q == COLLECT) begin
            if (bit_valid) begin
                crc_d     = crc_step;
                shreg_d   = {shreg_q[BLOCK_W-3:0], serial_in};
                bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
                if (bit_last) begin
                    last_block_d = {shreg_q, serial_in};
                    block_cnt_d  = (block_cnt_q == BLK_W'(NUM_BLOCKS)) ? block_cnt_q : block_cnt_q + 1'b1;
                    if (blk_last) begin
                        signature_d = crc_step;
                        pass_d      = crc_step == golden_sig;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
        end else begin
            overrun_d = overrun_q | bit_valid;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            crc_q        <= CRC_INIT;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            block_cnt_q  <= '0;
            last_block_q <= '0;
            signature_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            block_cnt_q  <= block_cnt_d;
            last_block_q <= last_block_d;
            signature_q  <= signature_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            overrun_q    <= overrun_d;
        end
    end

    assign last_block = last_block_q;
    assign block_cnt  = block_cnt_q;
    assign signature  = signature_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_scan_out_crc_checker.sv
// tb_scan_out_crc_checker: randomized frames checked against a polynomial-division CRC model.
module tb_scan_out_crc_checker;
    import scan_chk_pkg::*;

    logic         tck = 1'b0, reset_n = 1'b1, start = 1'b0, serial_in = 1'b0, bit_valid = 1'b0;
    logic [31:0]  golden_sig = '0;
    logic [127:0] last_block;
    logic [2:0]   block_cnt;
    logic [31:0]  signature;
    logic         busy, done, pass, overrun;
    logic [31:0]  k_last_block;
    logic [0:0]   k_block_cnt;
    logic [31:0]  k_signature;
    logic         k_busy, k_done, k_pass, k_overrun;

    int checks = 0, failures = 0, done_cnt = 0, k_done_cnt = 0;
    bit q[$];

    always #5 tck = ~tck;

    scan_out_crc_checker dut (
        .tck(tck), .reset_n(reset_n), .start(start), .serial_in(serial_in),
        .bit_valid(bit_valid), .golden_sig(golden_sig), .last_block(last_block),
        .block_cnt(block_cnt), .signature(signature), .busy(busy), .done(done),
        .pass(pass), .overrun(overrun)
    );

    scan_out_crc_checker #(.BLOCK_W(32), .NUM_BLOCKS(1), .CRC_INIT(32'h0)) dut_kat (
        .tck(tck), .reset_n(reset_n), .start(start), .serial_in(serial_in),
        .bit_valid(bit_valid), .golden_sig(golden_sig), .last_block(k_last_block),
        .block_cnt(k_block_cnt), .signature(k_signature), .busy(k_busy), .done(k_done),
        .pass(k_pass), .overrun(k_overrun)
    );

    always @(negedge tck) begin
        if (done) done_cnt++;
        if (k_done) k_done_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CRC as the remainder of (init*x^n + msg*x^32) mod P, by long division
    function automatic logic [31:0] ref_crc(input bit b[$], input logic [31:0] init);
        bit a[$];
        int n = b.size();
        logic [31:0] r;
        a = b;
        repeat (32) a.push_back(1'b0);
        for (int i = 0; i < 32 && i < n; i++) a[i] ^= init[31-i];
        for (int i = 0; i < n; i++)
            if (a[i]) for (int j = 0; j < 32; j++) a[i+1+j] ^= CRC32_POLY[31-j];
        for (int j = 0; j < 32; j++) r[31-j] = a[n+j];
        return r;
    endfunction

    function automatic logic [127:0] ref_last(input bit b[$], input int w);
        logic [127:0] r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = b[b.size()-w+i];
        return r;
    endfunction

    task automatic gen(input int n);
        q.delete();
        repeat (n) q.push_back(1'($urandom_range(1)));
    endtask

    task automatic pulse_start(input logic bv, input logic b);
        start = 1'b1; bit_valid = bv; serial_in = b;
        @(negedge tck);
        start = 1'b0; bit_valid = 1'b0;
    endtask

    task automatic send(input int stall_pct, input bit chk_blk, input int n);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < stall_pct) begin
                bit_valid = 1'b0; serial_in = 1'($urandom_range(1));
                @(negedge tck);
            end
            bit_valid = 1'b1; serial_in = q[i];
            @(negedge tck);
            if (chk_blk && (i + 1) % 128 == 0) check("block_cnt_step", block_cnt, (i + 1) / 128);
        end
        bit_valid = 1'b0;
    endtask

    task automatic frame_check(input string tag, input logic [31:0] exp_sig);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_sig"}, signature, exp_sig);
        check({tag, "_pass"}, pass, 1'b1);
        check({tag, "_last"}, last_block, ref_last(q, 128));
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_blkcnt"}, block_cnt, 3'd4);
        @(negedge tck);
        check({tag, "_done_low"}, done, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_last"}, last_block, '0);
        check({tag, "_blkcnt"}, block_cnt, '0);
        check({tag, "_sig"}, signature, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        logic [31:0] exp, sig0;
        int dc;
        #2 reset_n = 1'b0;
        @(negedge tck);
        check_zero("reset");
        check("reset_kat_sig", k_signature, '0);
        reset_n = 1'b1;
        @(negedge tck);

        // known answer and mismatch on the small instance
        for (int t = 0; t < 2; t++) begin
            logic [31:0] v = 32'h1;
            q.delete();
            for (int i = 31; i >= 0; i--) q.push_back(v[i]);
            golden_sig = t == 0 ? 32'h04C11DB7 : 32'h04C11DB6;
            dc = k_done_cnt;
            pulse_start(1'b0, 1'b0);
            send(0, 1'b0, 32);
            check("kat_done", k_done, 1'b1);
            check("kat_sig", k_signature, 32'h04C11DB7);
            check("kat_model", k_signature, ref_crc(q, 32'h0));
            check("kat_pass", k_pass, t == 0);
            check("kat_last", k_last_block, 32'h1);
            check("kat_blkcnt", k_block_cnt, 1'b1);
            @(negedge tck);
            check("kat_done_low", k_done, 1'b0);
            check("kat_done_cnt", k_done_cnt - dc, 1);
        end

        // same frame without and with ~30% stalls
        gen(512);
        exp = ref_crc(q, CRC32_INIT);
        golden_sig = exp;
        pulse_start(1'b0, 1'b0);
        send(0, 1'b1, 512);
        frame_check("nostall", exp);
        sig0 = signature;
        pulse_start(1'b0, 1'b0);
        send(30, 1'b1, 512);
        frame_check("stall", exp);
        check("stall_vs_nostall", signature, sig0);

        // abort after 200 bits; the bit presented with start is dropped
        dc = done_cnt;
        gen(200);
        pulse_start(1'b0, 1'b0);
        send(0, 1'b0, 200);
        pulse_start(1'b1, 1'($urandom_range(1)));
        check("abort_sig_held", signature, sig0);
        check("abort_busy", busy, 1'b1);
        gen(512);
        exp = ref_crc(q, CRC32_INIT);
        golden_sig = exp;
        send(0, 1'b1, 512);
        frame_check("abort", exp);
        check("abort_done_cnt", done_cnt - dc, 1);
        sig0 = signature;

        // start coincident with the final bit wins
        dc = done_cnt;
        gen(512);
        golden_sig = ref_crc(q, CRC32_INIT);
        pulse_start(1'b0, 1'b0);
        send(0, 1'b0, 511);
        pulse_start(1'b1, q[511]);
        check("coinc_done", done, 1'b0);
        check("coinc_busy", busy, 1'b1);
        check("coinc_blkcnt", block_cnt, '0);
        check("coinc_sig", signature, sig0);
        gen(512);
        exp = ref_crc(q, CRC32_INIT);
        golden_sig = exp;
        send(0, 1'b1, 512);
        frame_check("coinc", exp);
        check("coinc_done_cnt", done_cnt - dc, 1);

        // overrun in IDLE, cleared by start
        check("ovr_pre", overrun, 1'b0);
        repeat (3) begin
            bit_valid = 1'b1; serial_in = 1'($urandom_range(1));
            @(negedge tck);
        end
        bit_valid = 1'b0;
        check("ovr_set", overrun, 1'b1);
        check("ovr_busy", busy, 1'b0);
        check("ovr_sig_held", signature, exp);
        pulse_start(1'b0, 1'b0);
        check("ovr_clear", overrun, 1'b0);
        check("ovr_start_busy", busy, 1'b1);

        // asynchronous reset mid-frame
        dc = done_cnt;
        gen(512);
        send(0, 1'b1, 300);
        #2 reset_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge tck);
        reset_n = 1'b1;
        repeat (3) @(negedge tck);
        check("midreset_no_done", done_cnt - dc, 0);
        gen(512);
        exp = ref_crc(q, CRC32_INIT);
        golden_sig = exp;
        pulse_start(1'b0, 1'b0);
        send(20, 1'b1, 512);
        frame_check("postreset", exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
